chebyshev_feeder: RTL and testbench
===================================

Name: chebyshev_feeder

Overview:
Sequencer on the driving side of the Chebyshev computation core. Holds a coefficient table (ORDER+1 entries) and accepts one sample x per transaction through a valid/ready handshake. For each sample it clears the core, streams x with coefficients highest-order first on data_in/coeff_in, waits out the core latency, then captures the core's result and presents it through a valid/ready output.

Parameters:
WL, 2, word length of sample x / data_in
CL, 2, word length of coefficients / coeff_in
WIDENING, 0, extra result bits, passed through to core sizing
ORDER, 2, polynomial order; table depth ORDER+1
LATENCY, 2, core pipeline cycles from last coefficient to valid result_in
OUT (localparam), 2*WL+CL+WIDENING, result width
AW (localparam), max(1,$clog2(ORDER+1)), table address width

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
coeff_wr_en  in  1  coefficient write strobe
coeff_wr_addr  in  AW  coefficient index k (c_k)
coeff_wr_data  in  CL  signed coefficient value
coeff_wr_err  out  1  one-cycle pulse: write rejected
x_valid  in  1  sample offered
x_ready  out  1  feeder idle, sample accepted on x_valid&&x_ready
x_data  in  WL  signed sample
core_resetn  out  1  active-low clear to core
data_in  out  WL  sample to core
coeff_in  out  CL  coefficient to core
result_in  in  OUT  core data_out
result_valid  out  1  result_data valid
result_ready  in  1  downstream accepts result
result_data  out  OUT  captured signed result

Behaviour:
- Reset (reset=1 at edge): state IDLE, table cleared to 0, all outputs registered 0; core_resetn=0 while reset high. x_ready=0 while reset high.
- FSM: IDLE -> CLEAR -> STREAM -> DRAIN -> HOLD -> IDLE.
- IDLE: x_ready=1, core_resetn=1, data_in=0, coeff_in=0. On x_valid&&x_ready, latch x_data and go to CLEAR.
- CLEAR (1 cycle): core_resetn=0. Load the stream counter with ORDER.
- STREAM (ORDER+1 cycles): data_in=x, coeff_in=c[cnt]; cnt decrements ORDER..0, so the sequence is c_ORDER first and c_0 last. Exit to DRAIN after cnt==0.
- DRAIN (LATENCY cycles): data_in=x, coeff_in=0. On the last DRAIN cycle, register result_in into result_data.
- HOLD: result_valid=1, result_data stable. Return to IDLE on result_ready. result_ready=1 on HOLD's first cycle gives a one-cycle result_valid.
- Latency: result_valid rises ORDER+LATENCY+3 cycles after the accepting edge (7 with defaults). Throughput: one sample per ORDER+LATENCY+4 cycles minimum.
- result_ready outside HOLD: ignored.
- Coefficient writes: accepted only in IDLE with addr<=ORDER. Otherwise the table is unchanged and coeff_wr_err pulses for 1 cycle.
- A write and an accepted x in the same IDLE cycle: the write commits, and the transaction streams the new value.
- Widths: all data signed two's complement. The feeder does no arithmetic on data; result_data is a bit-exact copy of result_in.
- Reset mid-transaction: abort immediately to IDLE with reset values. No partial result is presented. The table is cleared.

Decomposition:
- Shared package: the state encoding enum (IDLE, CLEAR, STREAM, DRAIN, HOLD) and the OUT/AW width functions, so the core, feeder and benches size identically.
- One sub-module: chebyshev_coeff_table (ORDER+1 x CL register file, 1 write port, 1 combinational read port, range check producing coeff_wr_err). The FSM and counters stay in the top.

Test Plan:
- Reset: assert reset 2 cycles mid-STREAM -> next cycle state IDLE, x_ready=0 during reset and 1 after, result_valid=0, core_resetn=0 during reset, table reads 0.
- Stream order (defaults): write c0=2'b01, c1=2'b01, c2=2'b00; send x=2'b01.
  - Required: core_resetn low exactly 1 cycle.
  - Then coeff_in = 00,01,01 on 3 consecutive cycles with data_in=01.
  - Then coeff_in=00 for 2 cycles.
  - result_valid at cycle 7 after acceptance.
- Capture: core model drives result_in=6'sd5 on the last DRAIN cycle and 6'sd9 elsewhere -> result_data=5, held over 4 cycles of result_ready=0, then released 1 cycle after result_ready=1.
- Write rules: write addr=3 in IDLE -> coeff_wr_err pulse, table unchanged. Write during STREAM -> coeff_wr_err, the streamed values are unaffected.
- Simultaneous write and accept: in the IDLE accept cycle, write c2=2'b11 -> first STREAM coeff_in=11.
- Back-to-back: x_valid held high with result_ready=1 -> second sample accepted 1 cycle after HOLD, x_ready=0 throughout the busy states.

Source files
------------

// File: rtl/chebyshev_feeder_pkg.sv
// rtl/chebyshev_feeder_pkg.sv - shared state encoding and width helpers for the chebyshev feeder
package chebyshev_feeder_pkg;

    // Sequencer states, in the order a sample walks through them
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        HOLD   = 3'd4
    } feeder_state_e;

    // Bits needed to count 0..n, never narrower than one bit
    function automatic int count_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Core result width: full product of x*x*c plus any widening
    function automatic int out_width(input int wl, input int cl, input int widening);
        return 2 * wl + cl + widening;
    endfunction

    // Coefficient table index width for ORDER+1 entries
    function automatic int addr_width(input int order);
        return count_width(order);
    endfunction

endpackage

// File: rtl/chebyshev_feeder_if.sv
// rtl/chebyshev_feeder_if.sv - handshake and core-side bundle between the feeder and its neighbours
interface chebyshev_feeder_if
    import chebyshev_feeder_pkg::*;
#(
    parameter int WL       = 2,
    parameter int CL       = 2,
    parameter int WIDENING = 0,
    parameter int ORDER    = 2
);

    localparam int OUT = out_width(WL, CL, WIDENING);
    localparam int AW  = addr_width(ORDER);

    // Coefficient write port
    logic                  coeff_wr_en;
    logic [AW-1:0]         coeff_wr_addr;
    logic signed [CL-1:0]  coeff_wr_data;
    logic                  coeff_wr_err;

    // Sample input handshake
    logic                  x_valid;
    logic                  x_ready;
    logic signed [WL-1:0]  x_data;

    // Drive side of the computation core
    logic                  core_resetn;
    logic signed [WL-1:0]  data_in;
    logic signed [CL-1:0]  coeff_in;
    logic signed [OUT-1:0] result_in;

    // Result output handshake
    logic                  result_valid;
    logic                  result_ready;
    logic signed [OUT-1:0] result_data;

    // Environment view: writes coefficients, offers samples, models the core, consumes results
    modport master (
        output coeff_wr_en, coeff_wr_addr, coeff_wr_data,
        input  coeff_wr_err,
        output x_valid, x_data,
        input  x_ready,
        input  core_resetn, data_in, coeff_in,
        output result_in,
        input  result_valid, result_data,
        output result_ready
    );

    // Feeder view
    modport slave (
        input  coeff_wr_en, coeff_wr_addr, coeff_wr_data,
        output coeff_wr_err,
        input  x_valid, x_data,
        output x_ready,
        output core_resetn, data_in, coeff_in,
        input  result_in,
        output result_valid, result_data,
        input  result_ready
    );

endinterface

// File: rtl/chebyshev_feeder_coeff_table.sv
// rtl/chebyshev_feeder_coeff_table.sv - ORDER+1 entry coefficient register file with range-checked writes
module chebyshev_coeff_table
    import chebyshev_feeder_pkg::*;
#(
    parameter int CL    = 2,
    parameter int ORDER = 2,
    parameter int AW    = addr_width(ORDER)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_allow,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic signed [CL-1:0] wr_data,
    output logic                 wr_err,
    input  logic [AW-1:0]        rd_addr,
    output logic signed [CL-1:0] rd_data
);

    logic signed [CL-1:0] mem_q [ORDER+1];
    logic signed [CL-1:0] mem_d [ORDER+1];
    logic                 wr_ok;
    logic                 wr_err_q;
    logic                 wr_err_d;

    // Accept a write only when the owner allows it and the index exists; flag everything else
    always_comb begin
        mem_d    = mem_q;
        wr_ok    = wr_en && wr_allow && (int'(wr_addr) <= ORDER);
        wr_err_d = wr_en && !wr_ok;
        if (wr_ok) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Table storage and the one-cycle reject pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i <= ORDER; i++) begin
                mem_q[i] <= '0;
            end
            wr_err_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_err_q <= wr_err_d;
        end
    end

    // Combinational read; indices past the table read as zero
    always_comb begin
        rd_data = '0;
        if (int'(rd_addr) <= ORDER) begin
            rd_data = mem_q[rd_addr];
        end
    end

    assign wr_err = wr_err_q;

endmodule

// File: rtl/chebyshev_feeder.sv
// rtl/chebyshev_feeder.sv - sequences one sample and the coefficient table into the chebyshev core
module chebyshev_feeder
    import chebyshev_feeder_pkg::*;
#(
    parameter int WL       = 2,
    parameter int CL       = 2,
    parameter int WIDENING = 0,
    parameter int ORDER    = 2,
    parameter int LATENCY  = 2
) (
    input  logic              clock,
    input  logic              reset,
    chebyshev_feeder_if.slave bus
);

    localparam int OUT = out_width(WL, CL, WIDENING);
    localparam int AW  = addr_width(ORDER);
    localparam int DW  = count_width(LATENCY);

    localparam logic [AW-1:0] ORDER_IDX  = AW'(ORDER);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(LATENCY - 1);

    feeder_state_e         state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic [DW-1:0]         drain_q, drain_d;
    logic signed [WL-1:0]  x_q, x_d;
    logic signed [OUT-1:0] result_data_q, result_data_d;

    logic                  x_ready_q, x_ready_d;
    logic                  core_resetn_q, core_resetn_d;
    logic signed [WL-1:0]  data_in_q, data_in_d;
    logic signed [CL-1:0]  coeff_in_q, coeff_in_d;
    logic                  result_valid_q, result_valid_d;

    logic signed [CL-1:0]  rd_data;

    // Coefficients may only change while no sample is in flight; the read follows the next stream index
    chebyshev_coeff_table #(
        .CL    (CL),
        .ORDER (ORDER),
        .AW    (AW)
    ) u_table (
        .clock   (clock),
        .reset   (reset),
        .wr_allow(state_q == IDLE),
        .wr_en   (bus.coeff_wr_en),
        .wr_addr (bus.coeff_wr_addr),
        .wr_data (bus.coeff_wr_data),
        .wr_err  (bus.coeff_wr_err),
        .rd_addr (cnt_d),
        .rd_data (rd_data)
    );

    // Next state: accept, clear the core, stream c_ORDER..c_0, drain the pipeline, hold the result
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        drain_d       = drain_q;
        x_d           = x_q;
        result_data_d = result_data_q;
        unique case (state_q)
            IDLE: begin
                if (bus.x_valid && x_ready_q) begin
                    x_d     = bus.x_data;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d   = ORDER_IDX;
                state_d = STREAM;
            end
            STREAM: begin
                if (cnt_q == '0) begin
                    drain_d = DRAIN_LAST;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q - AW'(1);
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    result_data_d = bus.result_in;
                    state_d       = HOLD;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            HOLD: begin
                if (bus.result_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output values for the state being entered, so every output comes straight from a flop
    always_comb begin
        x_ready_d      = (state_d == IDLE);
        core_resetn_d  = (state_d != CLEAR);
        result_valid_d = (state_d == HOLD);
        data_in_d      = '0;
        coeff_in_d     = '0;
        if ((state_d == STREAM) || (state_d == DRAIN)) begin
            data_in_d = x_d;
        end
        if (state_d == STREAM) begin
            coeff_in_d = rd_data;
        end
    end

    // State and output registers; reset aborts any transaction and drops everything to zero
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            drain_q        <= '0;
            x_q            <= '0;
            result_data_q  <= '0;
            x_ready_q      <= 1'b0;
            core_resetn_q  <= 1'b0;
            data_in_q      <= '0;
            coeff_in_q     <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            drain_q        <= drain_d;
            x_q            <= x_d;
            result_data_q  <= result_data_d;
            x_ready_q      <= x_ready_d;
            core_resetn_q  <= core_resetn_d;
            data_in_q      <= data_in_d;
            coeff_in_q     <= coeff_in_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign bus.x_ready      = x_ready_q;
    assign bus.core_resetn  = core_resetn_q;
    assign bus.data_in      = data_in_q;
    assign bus.coeff_in     = coeff_in_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result_data  = result_data_q;

endmodule

// File: tb/tb_chebyshev_feeder.sv
// tb/tb_chebyshev_feeder.sv - directed self-checking bench for chebyshev_feeder
module tb_chebyshev_feeder;

    localparam int WL       = 2;
    localparam int CL       = 2;
    localparam int WIDENING = 0;
    localparam int ORDER    = 2;
    localparam int LATENCY  = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   since    = 0;

    always #5 clk = ~clk;

    chebyshev_feeder_if #(
        .WL(WL), .CL(CL), .WIDENING(WIDENING), .ORDER(ORDER)
    ) bus ();

    chebyshev_feeder #(
        .WL(WL), .CL(CL), .WIDENING(WIDENING), .ORDER(ORDER), .LATENCY(LATENCY)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    // Core model: cycles since the core was last cleared; 5 only on the last drain cycle
    always @(posedge clk) begin
        if (!bus.core_resetn) since <= 1;
        else if (since < 100) since <= since + 1;
    end
    assign bus.result_in = (since == ORDER + LATENCY + 1) ? 6'sd5 : 6'sd9;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] addr, input logic [1:0] data, input logic exp_err);
        bus.coeff_wr_en   = 1'b1;
        bus.coeff_wr_addr = addr;
        bus.coeff_wr_data = data;
        tick(1);
        bus.coeff_wr_en = 1'b0;
        chk("wr_err", bus.coeff_wr_err, exp_err);
    endtask

    // Offer x (optionally with a c2=11 write in the accept cycle) and check the whole sequence up to HOLD
    task automatic sample(input string tag, input logic [1:0] x, input logic with_wr,
                          input logic [1:0] c2, input logic [1:0] c1, input logic [1:0] c0);
        logic [1:0] exp_c [3];
        exp_c[0] = c2;
        exp_c[1] = c1;
        exp_c[2] = c0;
        bus.x_valid = 1'b1;
        bus.x_data  = x;
        if (with_wr) begin
            bus.coeff_wr_en   = 1'b1;
            bus.coeff_wr_addr = 2'd2;
            bus.coeff_wr_data = 2'b11;
        end
        tick(1);
        bus.x_valid     = 1'b0;
        bus.coeff_wr_en = 1'b0;
        chk({tag, "_clear_core_resetn"}, bus.core_resetn, 1'b0);
        chk({tag, "_clear_x_ready"}, bus.x_ready, 1'b0);
        if (with_wr) chk({tag, "_accept_wr_err"}, bus.coeff_wr_err, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk({tag, "_stream_core_resetn"}, bus.core_resetn, 1'b1);
            chk({tag, "_stream_coeff"}, unsigned'(bus.coeff_in), exp_c[i]);
            chk({tag, "_stream_data"}, unsigned'(bus.data_in), x);
        end
        for (int i = 0; i < 2; i++) begin
            tick(1);
            chk({tag, "_drain_coeff"}, unsigned'(bus.coeff_in), 2'b00);
            chk({tag, "_drain_data"}, unsigned'(bus.data_in), x);
            chk({tag, "_drain_valid"}, bus.result_valid, 1'b0);
        end
        tick(1);
        chk({tag, "_hold_valid"}, bus.result_valid, 1'b1);
        chk({tag, "_hold_data"}, unsigned'(bus.result_data), 6'd5);
    endtask

    task automatic release_result(input string tag);
        bus.result_ready = 1'b1;
        tick(1);
        bus.result_ready = 1'b0;
        chk({tag, "_released_valid"}, bus.result_valid, 1'b0);
        chk({tag, "_released_x_ready"}, bus.x_ready, 1'b1);
    endtask

    initial begin
        rst               = 1'b1;
        bus.coeff_wr_en   = 1'b0;
        bus.coeff_wr_addr = '0;
        bus.coeff_wr_data = '0;
        bus.x_valid       = 1'b0;
        bus.x_data        = '0;
        bus.result_ready  = 1'b0;
        tick(2);
        chk("rst_x_ready", bus.x_ready, 1'b0);
        chk("rst_core_resetn", bus.core_resetn, 1'b0);
        chk("rst_result_valid", bus.result_valid, 1'b0);
        chk("rst_wr_err", bus.coeff_wr_err, 1'b0);
        rst = 1'b0;
        tick(1);
        chk("idle_x_ready", bus.x_ready, 1'b1);
        chk("idle_core_resetn", bus.core_resetn, 1'b1);
        chk("idle_data_in", unsigned'(bus.data_in), 2'b00);
        chk("idle_coeff_in", unsigned'(bus.coeff_in), 2'b00);

        // Load c0=01, c1=01, c2=00 and run one sample; result held while result_ready is low
        wr(2'd0, 2'b01, 1'b0);
        wr(2'd1, 2'b01, 1'b0);
        wr(2'd2, 2'b00, 1'b0);
        sample("s1", 2'b01, 1'b0, 2'b00, 2'b01, 2'b01);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("hold_valid", bus.result_valid, 1'b1);
            chk("hold_data", unsigned'(bus.result_data), 6'd5);
        end
        release_result("s1");

        // Out-of-range write is rejected with a single-cycle pulse
        wr(2'd3, 2'b11, 1'b1);
        tick(1);
        chk("wr_err_pulse_end", bus.coeff_wr_err, 1'b0);

        // A write while busy is rejected and does not disturb the stream; early result_ready is ignored
        bus.x_valid = 1'b1;
        bus.x_data  = 2'b11;
        tick(1);
        bus.x_valid = 1'b0;
        chk("busy_clear_core_resetn", bus.core_resetn, 1'b0);
        tick(1);
        chk("busy_c2", unsigned'(bus.coeff_in), 2'b00);
        chk("busy_data", unsigned'(bus.data_in), 2'b11);
        bus.coeff_wr_en   = 1'b1;
        bus.coeff_wr_addr = 2'd0;
        bus.coeff_wr_data = 2'b11;
        tick(1);
        bus.coeff_wr_en = 1'b0;
        chk("busy_wr_err", bus.coeff_wr_err, 1'b1);
        chk("busy_c1", unsigned'(bus.coeff_in), 2'b01);
        tick(1);
        chk("busy_wr_err_end", bus.coeff_wr_err, 1'b0);
        chk("busy_c0", unsigned'(bus.coeff_in), 2'b01);
        tick(1);
        bus.result_ready = 1'b1;
        chk("busy_drain_valid", bus.result_valid, 1'b0);
        tick(1);
        chk("busy_drain_valid2", bus.result_valid, 1'b0);
        tick(1);
        chk("busy_hold_valid", bus.result_valid, 1'b1);
        chk("busy_hold_data", unsigned'(bus.result_data), 6'd5);
        tick(1);
        bus.result_ready = 1'b0;
        chk("busy_one_cycle_valid", bus.result_valid, 1'b0);
        chk("busy_back_idle", bus.x_ready, 1'b1);

        // Write c2=11 in the accept cycle: that same transaction streams 11 first
        sample("s2", 2'b10, 1'b1, 2'b11, 2'b01, 2'b01);
        release_result("s2");

        // Back-to-back: x_valid and result_ready held high; next accept at the end of the idle cycle
        bus.x_valid      = 1'b1;
        bus.x_data       = 2'b01;
        bus.result_ready = 1'b1;
        tick(1);
        for (int c = 1; c <= 9; c++) begin
            chk("b2b_x_ready", bus.x_ready, (c == 8));
            chk("b2b_result_valid", bus.result_valid, (c == 7));
            chk("b2b_core_resetn", bus.core_resetn, !((c == 1) || (c == 9)));
            if (c < 9) tick(1);
        end
        bus.x_valid = 1'b0;
        tick(6);
        chk("b2b_second_valid", bus.result_valid, 1'b1);
        chk("b2b_second_data", unsigned'(bus.result_data), 6'd5);
        tick(1);
        bus.result_ready = 1'b0;
        chk("b2b_second_done", bus.result_valid, 1'b0);
        chk("b2b_idle", bus.x_ready, 1'b1);

        // Reset mid-stream: abort, no result, table cleared
        bus.x_valid = 1'b1;
        bus.x_data  = 2'b01;
        tick(1);
        bus.x_valid = 1'b0;
        tick(1);
        chk("pre_rst_streaming", unsigned'(bus.data_in), 2'b01);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            chk("mid_rst_x_ready", bus.x_ready, 1'b0);
            chk("mid_rst_core_resetn", bus.core_resetn, 1'b0);
            chk("mid_rst_result_valid", bus.result_valid, 1'b0);
            chk("mid_rst_coeff_in", unsigned'(bus.coeff_in), 2'b00);
            chk("mid_rst_data_in", unsigned'(bus.data_in), 2'b00);
        end
        rst = 1'b0;
        tick(1);
        chk("post_rst_x_ready", bus.x_ready, 1'b1);
        chk("post_rst_core_resetn", bus.core_resetn, 1'b1);
        chk("post_rst_result_valid", bus.result_valid, 1'b0);
        sample("s3", 2'b01, 1'b0, 2'b00, 2'b00, 2'b00);
        release_result("s3");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
